uart_bus_arbiter: RTL
=====================

# uart_bus_arbiter

Sequencer and arbiter that shares the UART peripheral register interface (data register, control register with send bit 0 and rx-new bit 1) among several byte-transmit requesters. It performs the full transmit sequence (load data, set send, poll until the send bit clears) on behalf of the granted requester, and drains received bytes. It sits between the requesters and the UART peripheral's `reg_sel`/`wr`/write-data/read-data bus, replacing direct software access.

## Interface
- `N_REQ`, default 2: number of transmit requesters, 2..4.
- `TIMEOUT`, default 65535: maximum TX_WAIT poll cycles before the transfer is abandoned.

- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  N_REQ  per-requester transmit request; level, held until `done_o` bit.
- `req_data_i`  in  8*N_REQ  byte k at [8k+7:8k]; stable while `req_i[k]` is high.
- `done_o`  out  N_REQ  one-cycle pulse; transfer for requester k finished.
- `err_o`  out  1  one-cycle pulse coincident with `done_o` when the transfer timed out.
- `busy_o`  out  1  high in any state other than IDLE.
- `rx_valid_o`  out  1  one-cycle pulse; received byte on `rx_data_o`.
- `rx_data_o`  out  8  last received byte, held until the next pulse.
- `uart_wdata_o`  out  32  write data to the peripheral.
- `uart_reg_sel_o`  out  1  0 = control register, 1 = data register.
- `uart_wr_o`  out  1  write strobe, one cycle per write.
- `uart_rdata_i`  in  32  peripheral read data: control[1:0] zero-extended when sel=0, data byte when sel=1.

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, round-robin pointer 0, timeout counter 0.
- FSM states:
  - IDLE: issue a control read (sel=0, wr=0). If rx bit1 is set, go to RX_READ. Otherwise, if any `req_i` is set, grant the first set bit at or after the pointer, latch its byte and index, and go to TX_LOAD.
  - RX_READ: data read (sel=1). Latch `uart_rdata_i[7:0]` into `rx_data_o`. Go to RX_CLR.
  - RX_CLR: write control = 32'h0. Pulse `rx_valid_o`. Go to IDLE.
  - TX_LOAD: write data register = {24'h0, byte}. Go to TX_GO.
  - TX_GO: write control = 32'h1. Clear the timeout counter. Go to TX_WAIT.
  - TX_WAIT: control read each cycle. When bit0 is 0, go to TX_DONE. When the counter reaches TIMEOUT, go to TX_DONE and set the error flag.
  - TX_DONE: pulse `done_o[granted]`, and pulse `err_o` if the error flag is set. Set pointer = granted+1 mod N_REQ. Go to IDLE.
- RX has priority over TX at IDLE. RX is never serviced during TX_LOAD..TX_DONE, because writing 0 to control would cancel the send.
- An rx bit1 seen during TX_WAIT is not acted on. It is re-sampled on the IDLE read after TX_DONE.
- If a requester drops `req_i` after the grant, the transfer still completes and `done_o` still pulses.
- Requests are not queued. A requester whose `req_i` stays high after `done_o` is re-arbitrated normally.
- Reset asserted mid-transfer returns the FSM to IDLE at once. The outputs return to reset values. No partial write is retried.

## Timing
- Read data is sampled on the clock edge that ends the cycle in which `uart_reg_sel_o` is driven with `uart_wr_o`=0. This gives zero-wait combinational read data.
- Write strobes are exactly one cycle wide. Back-to-back writes occur in TX_LOAD→TX_GO.
- Minimum transfer, request at IDLE to `done_o`:
  - 1 IDLE cycle.
  - TX_LOAD, TX_GO.
  - ≥1 TX_WAIT.
  - TX_DONE.
  - Total: 5 cycles.
- RX drain: 3 cycles (IDLE, RX_READ, RX_CLR).
- Arbitration is decided only in IDLE. No starvation: any held request is served within N_REQ transfers plus any interleaved RX drains.

## Configuration
- `UART_ARB_RX_EN` defined: RX polling and the RX_READ/RX_CLR states are present, as described above.
- `UART_ARB_RX_EN` undefined:
  - The RX states are removed.
  - Bit1 is ignored.
  - `rx_valid_o` and `rx_data_o` are tied to 0.
  - The IDLE control read is not issued; IDLE drives sel=0, wr=0 with no sampling.

## Structure
- Shared package `uart_arb_pkg`:
  - State enum `uart_arb_state_t`.
  - Register-select constants `SEL_CTRL`=0 and `SEL_DATA`=1.
  - Control bit indices `CTRL_SEND`=0 and `CTRL_RXNEW`=1.
- One sub-module, `rr_arbiter`: combinational N_REQ round-robin grant from `req` and pointer, returning a one-hot grant and an index. The FSM, counter and latches stay in the top.

## Test plan
- Reset with `reset_i`=0: all outputs 0. Release, with no requests and bit1=0: only control reads (sel=0, wr=0) occur, `busy_o`=0.
- `req_i`=2'b01, byte 8'hA5; the model clears bit0 after 10 cycles:
  - Writes occur in the order data=32'hA5, then control=32'h1.
  - `done_o`=2'b01 pulses once.
  - `err_o`=0.
- `req_i`=2'b11 held for 3 transfers: grants alternate 0,1,0. Each `done_o` pulse carries its requester's byte.
- Model sets bit1 with data 8'h3C while `req_i`[0] is pending:
  - The RX drain runs first.
  - `rx_valid_o` pulses with 8'h3C.
  - Control 32'h0 is written.
  - The TX follows.
- Model never clears bit0, with TIMEOUT=15: `done_o` and `err_o` pulse together 16 TX_WAIT cycles after TX_GO.
- `reset_i` asserted during TX_WAIT: FSM is in IDLE next cycle, outputs are 0, and no `done_o` pulse occurs.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_arb_pkg
// Brief   : Shared types and constants for the UART bus arbiter.
// Revision: 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_LOAD  = 3'd1,
    TX_GO    = 3'd2,
    TX_WAIT  = 3'd3,
    TX_DONE  = 3'd4
`ifdef UART_ARB_RX_EN
    ,
    RX_READ  = 3'd5,
    RX_CLR   = 3'd6
`endif
  } uart_arb_state_t;

  localparam logic SEL_CTRL   = 1'b0;
  localparam logic SEL_DATA   = 1'b1;
  localparam int   CTRL_SEND  = 0;
  localparam int   CTRL_RXNEW = 1;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_bus_arbiter_if
// Brief   : Register bus between the arbiter (master) and the UART (slave).
// Revision: 1.0  initial release
// ============================================================================
interface uart_bus_arbiter_if;
  import uart_arb_pkg::*;

  logic [31:0] uart_wdata_o;
  logic        uart_reg_sel_o;
  logic        uart_wr_o;
  logic [31:0] uart_rdata_i;

  modport master (
    output uart_wdata_o,
    output uart_reg_sel_o,
    output uart_wr_o,
    input  uart_rdata_i
  );

  modport slave (
    input  uart_wdata_o,
    input  uart_reg_sel_o,
    input  uart_wr_o,
    output uart_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/uart_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin grant; first request at or after ptr.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % N_REQ]) begin
        any                              = 1'b1;
        grant[(int'(ptr) + i) % N_REQ]   = 1'b1;
        idx                              = IDX_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_bus_arbiter
// Brief   : Shares the UART register bus among N_REQ byte senders and drains
//           received bytes. RX draining is built only with UART_ARB_RX_EN.
// Revision: 1.0  initial release
// ============================================================================
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   done_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               rx_valid_o,
  output logic [7:0]         rx_data_o,
  uart_bus_arbiter_if.master uart
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] c_last    = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  uart_arb_state_t  r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [N_REQ-1:0] r_gnt_oh, w_gnt_oh_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tmo, w_tmo_nxt;

  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_sel, w_sel_nxt;
  logic             r_wr, w_wr_nxt;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_unused_rdata;

  assign w_unused_rdata = ^uart.uart_rdata_i;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (req_i),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

`ifdef UART_ARB_RX_EN
  logic       r_rx_valid, w_rx_valid_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
`endif

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_gnt_oh_nxt  = r_gnt_oh;
    w_byte_nxt    = r_byte;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
`ifdef UART_ARB_RX_EN
    w_rx_data_nxt = r_rx_data;
`endif

    case (r_state)
      IDLE: begin
`ifdef UART_ARB_RX_EN
        if (uart.uart_rdata_i[CTRL_RXNEW]) begin
          w_state_nxt = RX_READ;
        end else
`endif
        if (w_any) begin
          w_state_nxt   = TX_LOAD;
          w_gnt_idx_nxt = w_idx;
          w_gnt_oh_nxt  = w_grant;
          w_byte_nxt    = req_data_i[{w_idx, 3'b000} +: 8];
        end
      end
`ifdef UART_ARB_RX_EN
      RX_READ: begin
        w_rx_data_nxt = uart.uart_rdata_i[7:0];
        w_state_nxt   = RX_CLR;
      end
      RX_CLR: begin
        w_state_nxt = IDLE;
      end
`endif
      TX_LOAD: begin
        w_state_nxt = TX_GO;
      end
      TX_GO: begin
        w_cnt_nxt   = '0;
        w_tmo_nxt   = 1'b0;
        w_state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (!uart.uart_rdata_i[CTRL_SEND]) begin
          w_state_nxt = TX_DONE;
        end else if (r_cnt == c_timeout) begin
          w_state_nxt = TX_DONE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      TX_DONE: begin
        w_ptr_nxt   = (r_gnt_idx == c_last) ? '0 : r_gnt_idx + 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_sel_nxt   = SEL_CTRL;
    w_wr_nxt    = 1'b0;
    w_wdata_nxt = '0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = (w_state_nxt != IDLE);
`ifdef UART_ARB_RX_EN
    w_rx_valid_nxt = 1'b0;
`endif

    case (w_state_nxt)
`ifdef UART_ARB_RX_EN
      RX_READ: begin
        w_sel_nxt = SEL_DATA;
      end
      RX_CLR: begin
        w_wr_nxt       = 1'b1;
        w_rx_valid_nxt = 1'b1;
      end
`endif
      TX_LOAD: begin
        w_sel_nxt   = SEL_DATA;
        w_wr_nxt    = 1'b1;
        w_wdata_nxt = byte_word(w_byte_nxt);
      end
      TX_GO: begin
        w_wr_nxt    = 1'b1;
        w_wdata_nxt = 32'h1 << CTRL_SEND;
      end
      TX_DONE: begin
        w_done_nxt = w_gnt_oh_nxt;
        w_err_nxt  = w_tmo_nxt;
      end
      default: begin
        w_sel_nxt = SEL_CTRL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_byte    <= '0;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_wdata   <= '0;
      r_sel     <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_gnt_oh  <= w_gnt_oh_nxt;
      r_byte    <= w_byte_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_wdata   <= w_wdata_nxt;
      r_sel     <= w_sel_nxt;
      r_wr      <= w_wr_nxt;
    end
  end

`ifdef UART_ARB_RX_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_data  <= w_rx_data_nxt;
    end
  end

  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
`else
  assign rx_valid_o = 1'b0;
  assign rx_data_o  = 8'h00;
`endif

  assign done_o              = r_done;
  assign err_o               = r_err;
  assign busy_o              = r_busy;
  assign uart.uart_wdata_o   = r_wdata;
  assign uart.uart_reg_sel_o = r_sel;
  assign uart.uart_wr_o      = r_wr;

endmodule
`default_nettype wire
